grf_scoreboard: RTL and testbench
=================================

# grf_scoreboard

Pending-write tracker for the general register file, sitting at the decode stage of the five-stage pipeline. It records every in-flight write to the register file when an instruction issues and clears it when writeback commits. Decode reads use it to decide whether the register file value can be used, must be forwarded, or requires a stall. It mirrors the register file's write port and serves its readers.

## Interface
Parameters:
- NREG, 32, number of architectural registers; index width is 5.
- CNTW, 2, pending-counter width; at most 3 in-flight writers per register.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- issue_valid  in  1  instruction in decode wants to leave decode with RegWrite set.
- issue_a3  in  5  destination register of the issuing instruction.
- issue_tnew  in  2  cycles from issue until the result becomes forwardable.
- rd_a1, rd_a2  in  5  source registers read in decode.
- rd_tuse1, rd_tuse2  in  2  cycles from decode until each source value is consumed.
- wb_regwrite  in  1  register file write-enable from writeback, same signal the register file sees.
- wb_a3  in  5  writeback destination.
- stall  out  1  decode must hold; issue is suppressed internally.
- pend1, pend2  out  1  source has an outstanding writer not retiring this cycle.
- tnew1, tnew2  out  2  remaining cycles for the youngest writer of each source.
- err_ovf  out  1  sticky; an issue found a counter already saturated.
- err_unf  out  1  sticky; a retire found a counter already at 0.

## Operation
- State per register r: cnt[r] (CNTW bits), which counts outstanding writers, and tn[r] (2 bits), the countdown of the youngest writer.
- issue_fire = issue_valid & ~stall & (issue_a3 != 0).
- retire = wb_regwrite & (wb_a3 != 0).
- Register 0 is never tracked. cnt[0] and tn[0] are held at 0, so pend and stall are 0 for source 0.
- Counter update at each posedge:
  - issue_fire only: cnt += 1.
  - retire only: cnt -= 1.
  - Both on the same register: cnt is unchanged.
  - Both on different registers: each updates independently.
- Saturation and errors:
  - Issue when cnt == 3: cnt stays at 3 and err_ovf is set.
  - Retire when cnt == 0 (and no simultaneous issue to that register): cnt stays at 0 and err_unf is set.
- Countdown update at each posedge, for every r:
  - If issue_fire targets r: tn[r] <= issue_tnew.
  - Otherwise, if tn[r] != 0: tn[r] <= tn[r] - 1.
  - Otherwise tn[r] holds.
- Read side (combinational from registered state), for source k:
  - pendk = (cnt[a] != 0) & ~(retire & wb_a3 == a & cnt[a] == 1). A retire in the same cycle counts as resolved, because the register file bypasses WD to its read ports.
  - tnewk = pendk ? tn[a] : 0.
  - stall = (pend1 & tnew1 > rd_tuse1) | (pend2 & tnew2 > rd_tuse2).
- The issuing instruction's own destination never affects its own stall; reads see pre-edge state only.

## Timing
- Reset: all cnt, all tn, err_ovf and err_unf are 0. Consequently stall, pend1/2 and tnew1/2 are 0.
- Reset takes priority over issue and retire in the same cycle.
- Reset mid-operation discards all pending state; the pipeline is flushed by the same reset.
- Issue or retire at cycle N updates state at the edge ending N; the effect is visible on outputs in cycle N+1.
- The same-cycle retire exemption in pendk is the only zero-latency path.
- stall depends combinationally on rd_* and wb_*. There is no path from issue_valid to stall.
- Tuple of a retire and a new issue to the same register in one cycle: the count is unchanged and tn is reloaded to issue_tnew.

## Structure
- Shared package / header:
  - NREG, CNTW.
  - Tuse/Tnew encodings: TUSE_ID = 0, TUSE_EX = 1, TNEW_ALU = 1, TNEW_LOAD = 2.
  - Register-0 constant.
- Sub-module sb_entry holds one register's cnt/tn update logic. It is instantiated 31 times in a generate loop; read muxing and stall logic live in the top module.

## Test plan
- Reset, then read a1 = 5, a2 = 6 -> stall = 0, pend = 0, tnew = 0, errors = 0.
- Issue a3 = 8, tnew = 2, then next cycle read a1 = 8 with tuse = 0 -> pend1 = 1, tnew1 = 2, stall = 1. One cycle later tnew1 = 1, stall = 1. After that tnew1 = 0, stall = 0, pend1 = 1.
- Issue a3 = 8, then retire wb_a3 = 8 while reading a1 = 8 in that same retire cycle -> pend1 = 0, stall = 0. cnt[8] = 0 afterwards.
- Issue a3 = 9 three times, then issue again -> err_ovf = 1, cnt[9] = 3. Retire four times -> err_unf = 1 on the fourth retire.
- Issue a3 = 0 with tnew = 3, then read a1 = 0 -> pend1 = 0, stall = 0. Retire wb_a3 = 0 -> err_unf stays 0.
- Two writers pending on register 10, then issue and retire register 10 in the same cycle -> cnt stays 2, tnew reloaded. Assert reset mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/grf_scoreboard_pkg.sv
// Shared types and encodings for the general-register-file pending-write scoreboard.
package grf_scoreboard_pkg;
  localparam int SB_NREG = 32;
  localparam int SB_CNTW = 2;
  localparam int AW      = 5;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [1:0]    tn_t;

  localparam tn_t TUSE_ID   = 2'd0;
  localparam tn_t TUSE_EX   = 2'd1;
  localparam tn_t TNEW_ALU  = 2'd1;
  localparam tn_t TNEW_LOAD = 2'd2;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/grf_scoreboard_if.sv
// Decode-stage issue/read/writeback bundle between the pipeline and the scoreboard.
interface grf_scoreboard_if;
  import grf_scoreboard_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_a3;
  tn_t      issue_tnew;
  reg_idx_t rd_a1;
  reg_idx_t rd_a2;
  tn_t      rd_tuse1;
  tn_t      rd_tuse2;
  logic     wb_regwrite;
  reg_idx_t wb_a3;
  logic     stall;
  logic     pend1;
  logic     pend2;
  tn_t      tnew1;
  tn_t      tnew2;
  logic     err_ovf;
  logic     err_unf;

  modport master (
    output issue_valid, issue_a3, issue_tnew, rd_a1, rd_a2, rd_tuse1, rd_tuse2,
           wb_regwrite, wb_a3,
    input  stall, pend1, pend2, tnew1, tnew2, err_ovf, err_unf
  );

  modport slave (
    input  issue_valid, issue_a3, issue_tnew, rd_a1, rd_a2, rd_tuse1, rd_tuse2,
           wb_regwrite, wb_a3,
    output stall, pend1, pend2, tnew1, tnew2, err_ovf, err_unf
  );
endinterface

// File: rtl/grf_scoreboard_sb_entry.sv
// One register's writer count and youngest-writer countdown; reports saturation events.
module sb_entry
  import grf_scoreboard_pkg::*;
#(
  parameter int CNTW = SB_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  input  tn_t             tnew_in,
  output logic [CNTW-1:0] cnt,
  output tn_t             tn,
  output logic            ovf,
  output logic            unf
);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  tn_t             tn_q, tn_d;

  always_comb begin
    cnt_d = cnt_q;
    tn_d  = tn_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    // A simultaneous issue and retire cancel; only a lone event moves the count.
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) unf = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
    if (inc)               tn_d = tnew_in;
    else if (tn_q != 2'd0) tn_d = tn_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tn_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tn_q  <= tn_d;
    end
  end

  assign cnt = cnt_q;
  assign tn  = tn_q;
endmodule

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard for the register file: tracks in-flight writers and
// resolves decode reads into use / forward / stall.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int NREG = SB_NREG,
  parameter int CNTW = SB_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  grf_scoreboard_if.slave  sb
);
  logic [CNTW-1:0] cnt [NREG];
  tn_t             tn  [NREG];
  logic [NREG-1:0] ovf_vec, unf_vec;
  logic            issue_fire, retire;
  logic            pend1, pend2, stall;
  tn_t             tnew1, tnew2;
  logic            err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

  // Writeback in the same cycle resolves the last writer: the file bypasses WD to its reads.
  function automatic logic src_pending(logic [CNTW-1:0] c, reg_idx_t a,
                                       logic ret, reg_idx_t wa);
    return (c != '0) && !(ret && (wa == a) && (c == CNTW'(1)));
  endfunction

  assign cnt[0]     = '0;
  assign tn[0]      = '0;
  assign ovf_vec[0] = 1'b0;
  assign unf_vec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(.CNTW(CNTW)) u_entry (
      .clk     (clk),
      .reset   (reset),
      .inc     (issue_fire && (sb.issue_a3 == reg_idx_t'(r))),
      .dec     (retire && (sb.wb_a3 == reg_idx_t'(r))),
      .tnew_in (sb.issue_tnew),
      .cnt     (cnt[r]),
      .tn      (tn[r]),
      .ovf     (ovf_vec[r]),
      .unf     (unf_vec[r])
    );
  end

  always_comb begin
    retire = sb.wb_regwrite && (sb.wb_a3 != REG_ZERO);
    pend1  = src_pending(cnt[sb.rd_a1], sb.rd_a1, retire, sb.wb_a3);
    pend2  = src_pending(cnt[sb.rd_a2], sb.rd_a2, retire, sb.wb_a3);
    tnew1  = pend1 ? tn[sb.rd_a1] : '0;
    tnew2  = pend2 ? tn[sb.rd_a2] : '0;
    stall  = (pend1 && (tnew1 > sb.rd_tuse1)) || (pend2 && (tnew2 > sb.rd_tuse2));
  end

  assign issue_fire = sb.issue_valid && !stall && (sb.issue_a3 != REG_ZERO);

  always_comb begin
    err_ovf_d = err_ovf_q | (|ovf_vec);
    err_unf_d = err_unf_q | (|unf_vec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign sb.stall   = stall;
  assign sb.pend1   = pend1;
  assign sb.pend2   = pend2;
  assign sb.tnew1   = tnew1;
  assign sb.tnew2   = tnew2;
  assign sb.err_ovf = err_ovf_q;
  assign sb.err_unf = err_unf_q;
endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: directed scenarios plus random traffic,
// checked against a per-register writer-count reference model.
module tb_grf_scoreboard;
  import grf_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_scoreboard_if sb_if ();

  grf_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  typedef struct packed {
    logic       stall;
    logic       pend1;
    logic       pend2;
    logic [1:0] tnew1;
    logic [1:0] tnew2;
    logic       ovf;
    logic       unf;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   checks = 0;
  int   errors = 0;

  // Reference model: outstanding writers per register (capped at 3) and youngest countdown.
  int m_cnt [32];
  int m_tn  [32];
  bit m_ovf, m_unf;

  function automatic int rnd(int lo, int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic bit m_pend(int a, bit wr, int wa);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    if (wr && wa == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_tn[r]  = 0;
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic step(input bit rst, input bit iv, input int a3, input int itn,
                      input int a1, input int u1, input int a2, input int u2,
                      input bit wr, input int wa);
    obs_t e;
    bit   p1, p2, st, fire, ret;
    int   t1, t2;
    reset             = rst;
    sb_if.issue_valid = iv;
    sb_if.issue_a3    = 5'(a3);
    sb_if.issue_tnew  = 2'(itn);
    sb_if.rd_a1       = 5'(a1);
    sb_if.rd_tuse1    = 2'(u1);
    sb_if.rd_a2       = 5'(a2);
    sb_if.rd_tuse2    = 2'(u2);
    sb_if.wb_regwrite = wr;
    sb_if.wb_a3       = 5'(wa);
    ret = wr && (wa != 0);
    p1  = m_pend(a1, ret, wa);
    p2  = m_pend(a2, ret, wa);
    t1  = p1 ? m_tn[a1] : 0;
    t2  = p2 ? m_tn[a2] : 0;
    st  = (p1 && t1 > u1) || (p2 && t2 > u2);
    e.stall = st;
    e.pend1 = p1;
    e.pend2 = p2;
    e.tnew1 = 2'(t1);
    e.tnew2 = 2'(t2);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      fire = iv && !st && (a3 != 0);
      if (fire && !(ret && wa == a3)) begin
        if (m_cnt[a3] == 3) m_ovf = 1'b1;
        else                m_cnt[a3] = m_cnt[a3] + 1;
      end
      if (ret && !(fire && a3 == wa)) begin
        if (m_cnt[wa] == 0) m_unf = 1'b1;
        else                m_cnt[wa] = m_cnt[wa] - 1;
      end
      for (int r = 1; r < 32; r++) begin
        if (fire && a3 == r)  m_tn[r] = itn;
        else if (m_tn[r] > 0) m_tn[r] = m_tn[r] - 1;
      end
    end
    #1;
  endtask

  // Shorthands: idle cycle with reads, and a pure reset cycle.
  task automatic rd(input int a1, input int u1, input int a2, input int u2);
    step(1'b0, 1'b0, 0, 0, a1, u1, a2, u2, 1'b0, 0);
  endtask

  task automatic rst_cycle();
    step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act.stall = sb_if.stall;
      mon_act.pend1 = sb_if.pend1;
      mon_act.pend2 = sb_if.pend2;
      mon_act.tnew1 = sb_if.tnew1;
      mon_act.tnew2 = sb_if.tnew2;
      mon_act.ovf   = sb_if.err_ovf;
      mon_act.unf   = sb_if.err_unf;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL outputs t=%0t got stall=%b pend=%b%b tnew=%0d/%0d ovf=%b unf=%b, want stall=%b pend=%b%b tnew=%0d/%0d ovf=%b unf=%b",
                 $time, mon_act.stall, mon_act.pend1, mon_act.pend2, mon_act.tnew1, mon_act.tnew2,
                 mon_act.ovf, mon_act.unf, mon_exp.stall, mon_exp.pend1, mon_exp.pend2,
                 mon_exp.tnew1, mon_exp.tnew2, mon_exp.ovf, mon_exp.unf);
      end
    end
  end

  initial begin
    reset             = 1'b1;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_a3    = '0;
    sb_if.issue_tnew  = '0;
    sb_if.rd_a1       = '0;
    sb_if.rd_a2       = '0;
    sb_if.rd_tuse1    = '0;
    sb_if.rd_tuse2    = '0;
    sb_if.wb_regwrite = 1'b0;
    sb_if.wb_a3       = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Clean state after reset.
    rd(5, TUSE_ID, 6, TUSE_ID);

    // Load-like writer on r8 counts down while a decode read waits on it.
    step(1'b0, 1'b1, 8, TNEW_LOAD, 0, 0, 0, 0, 1'b0, 0);
    rd(8, TUSE_ID, 0, 0);
    rd(8, TUSE_ID, 0, 0);
    rd(8, TUSE_ID, 0, 0);
    rd(8, TUSE_EX, 8, TUSE_ID);
    rst_cycle();

    // Writeback in the read cycle resolves the only writer.
    step(1'b0, 1'b1, 8, TNEW_ALU, 0, 0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 0, 8, TUSE_ID, 8, TUSE_ID, 1'b1, 8);
    rd(8, TUSE_ID, 0, 0);

    // Saturate r9, then drain it one past empty.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 9, TNEW_ALU, 9, TUSE_EX, 0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, 9, TUSE_EX, 9, TUSE_ID, 1'b1, 9);
    rd(9, TUSE_ID, 0, 0);
    rst_cycle();

    // Register 0 is never tracked.
    step(1'b0, 1'b1, 0, 3, 0, 0, 0, 0, 1'b0, 0);
    rd(0, TUSE_ID, 0, TUSE_ID);
    step(1'b0, 1'b0, 0, 0, 0, TUSE_ID, 0, 0, 1'b1, 0);
    rd(0, TUSE_ID, 0, TUSE_ID);

    // Two writers on r10, then issue+retire together, then reset mid-flight.
    step(1'b0, 1'b1, 10, TNEW_ALU, 0, 0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 10, TNEW_ALU, 0, 0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 10, 3, 10, TUSE_EX, 0, 0, 1'b1, 10);
    rd(10, TUSE_ID, 10, TUSE_EX);
    step(1'b0, 1'b0, 0, 0, 10, TUSE_ID, 0, 0, 1'b1, 10);
    rd(10, TUSE_ID, 0, 0);
    rst_cycle();
    rd(10, TUSE_ID, 10, TUSE_ID);

    // Random traffic concentrated on a few registers so hazards collide often.
    for (int i = 0; i < 2000; i++) begin
      step(rnd(0, 149) == 0, rnd(0, 1) == 1, rnd(0, 4), rnd(0, 3),
           rnd(0, 4), rnd(0, 3), rnd(0, 4), rnd(0, 3),
           rnd(0, 2) == 0, rnd(0, 4));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
